cache_line_adaptor: RTL and testbench

- Sits between the cache data array/controller and physical memory.
- Converts one 256-bit cache line into a 4-beat x 64-bit memory burst for writeback, and assembles a 4-beat burst into a 256-bit line for fill.
- On fill completion it drives a full-line write (all 32 byte-enables) to the data array.
- Write (writeback) has priority over read (fill), so dirty evictions complete before refill.

---
 rtl/cache_types_pkg.sv | 19 +
 rtl/cache_line_adaptor_if.sv | 49 ++++
 rtl/cache_line_adaptor.sv | 167 ++++++++++++++++
 tb/tb_cache_line_adaptor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Shared types and constants for the cache line adaptor.
// Defines the beat/line geometry and the adaptor state encoding.
package cache_types_pkg;

    localparam int unsigned BEAT_W      = 64;
    localparam int unsigned BEATS       = 4;
    localparam int unsigned LINE_W      = BEATS * BEAT_W;
    localparam int unsigned OFFSET_BITS = 5;

    typedef logic [255:0] cache_line_t;

    typedef enum logic [1:0] {
        StIdle,
        StWrBurst,
        StRdBurst,
        StDone
    } line_adaptor_state_t;

endpackage

// File: rtl/cache_line_adaptor_if.sv
// Cache-side and memory-side signals of the line adaptor.
// err_o exists only when LINE_ADAPTOR_TIMEOUT_EN is defined.
interface cache_line_adaptor_if #(
    parameter int unsigned BEATS  = cache_types_pkg::BEATS,
    parameter int unsigned BEAT_W = cache_types_pkg::BEAT_W
);

    localparam int unsigned LINE_W = BEATS * BEAT_W;

    // Cache controller / data array side
    logic                  read_i;
    logic                  write_i;
    logic [31:0]           address_i;
    logic [LINE_W-1:0]     line_i;
    logic [LINE_W-1:0]     line_o;
    logic [LINE_W/8-1:0]   line_we_o;
    logic                  resp_o;

    // Physical memory side
    logic [31:0]           address_o;
    logic                  read_o;
    logic                  write_o;
    logic [BEAT_W-1:0]     burst_o;
    logic [BEAT_W-1:0]     burst_i;
    logic                  resp_i;

`ifdef LINE_ADAPTOR_TIMEOUT_EN
    logic                  err_o;
`endif

    // Environment view: cache controller plus memory
    modport master (
        output read_i, write_i, address_i, line_i, burst_i, resp_i,
        input  line_o, line_we_o, resp_o, address_o, read_o, write_o, burst_o
`ifdef LINE_ADAPTOR_TIMEOUT_EN
        , input err_o
`endif
    );

    // Adaptor view
    modport slave (
        input  read_i, write_i, address_i, line_i, burst_i, resp_i,
        output line_o, line_we_o, resp_o, address_o, read_o, write_o, burst_o
`ifdef LINE_ADAPTOR_TIMEOUT_EN
        , output err_o
`endif
    );

endinterface

// File: rtl/cache_line_adaptor.sv
// Bridges a 256-bit cache line to a 4 x 64-bit memory burst (writeback and fill).
// Define LINE_ADAPTOR_TIMEOUT_EN to add a burst watchdog and the sticky err_o flag.
module cache_line_adaptor #(
    parameter int unsigned BEATS   = cache_types_pkg::BEATS,
    parameter int unsigned BEAT_W  = cache_types_pkg::BEAT_W,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 rst_n,
    cache_line_adaptor_if.slave bus
);

    import cache_types_pkg::*;

    localparam int unsigned LINE_W = BEATS * BEAT_W;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    line_adaptor_state_t state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   shadow_q, shadow_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [31:0]         addr_q, addr_d;
    logic                fill_q, fill_d;

    logic in_burst;
    logic timeout_hit;
    logic commit_ok;

    assign in_burst = (state_q == StWrBurst) || (state_q == StRdBurst);

`ifdef LINE_ADAPTOR_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;
    logic       err_q, err_d;
    logic       tmo_q, tmo_d;

    // Counts consecutive burst cycles without a beat; any beat or leaving the burst clears it.
    assign timeout_hit = in_burst && !bus.resp_i && (wdog_q == 8'(TIMEOUT - 1));

    always_comb begin
        wdog_d = wdog_q;
        err_d  = err_q;
        tmo_d  = tmo_q;
        if (!in_burst || bus.resp_i) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + 8'd1;
        end
        if (timeout_hit) begin
            err_d = 1'b1;
            tmo_d = 1'b1;
        end else if (state_q == StIdle) begin
            tmo_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
            tmo_q  <= tmo_d;
        end
    end

    // A fill that timed out is never committed to the data array.
    assign commit_ok = !tmo_q;
    assign bus.err_o = err_q;
`else
    logic [31:0] unused_timeout;

    assign timeout_hit    = 1'b0;
    assign commit_ok      = 1'b1;
    assign unused_timeout = TIMEOUT;
`endif

    logic unused_addr_offset;
    assign unused_addr_offset = ^bus.address_i[OFFSET_BITS-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        line_d   = line_q;
        addr_d   = addr_q;
        fill_d   = fill_q;

        unique case (state_q)
            StIdle: begin
                // Writeback wins so a dirty victim leaves before its replacement arrives.
                if (bus.write_i) begin
                    shadow_d = bus.line_i;
                    addr_d   = {bus.address_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    cnt_d    = '0;
                    fill_d   = 1'b0;
                    state_d  = StWrBurst;
                end else if (bus.read_i) begin
                    addr_d  = {bus.address_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    cnt_d   = '0;
                    fill_d  = 1'b1;
                    state_d = StRdBurst;
                end
            end

            StWrBurst: begin
                if (timeout_hit) begin
                    state_d = StDone;
                end else if (bus.resp_i) begin
                    cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = StDone;
                    end
                end
            end

            StRdBurst: begin
                if (timeout_hit) begin
                    state_d = StDone;
                end else if (bus.resp_i) begin
                    line_d[cnt_q*BEAT_W +: BEAT_W] = bus.burst_i;
                    cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
            line_q   <= '0;
            addr_q   <= '0;
            fill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            line_q   <= line_d;
            addr_q   <= addr_d;
            fill_q   <= fill_d;
        end
    end

    assign bus.read_o    = (state_q == StRdBurst);
    assign bus.write_o   = (state_q == StWrBurst);
    assign bus.resp_o    = (state_q == StDone);
    assign bus.address_o = addr_q;
    assign bus.line_o    = line_q;
    assign bus.burst_o   = (state_q == StWrBurst) ? shadow_q[cnt_q*BEAT_W +: BEAT_W] : '0;
    assign bus.line_we_o = ((state_q == StDone) && fill_q && commit_ok) ? '1 : '0;

endmodule

// File: tb/tb_cache_line_adaptor.sv
// Scoreboard bench for cache_line_adaptor: a random memory responder feeds beats,
// expected lines/beats are queued at issue time and checked by an independent monitor.
module tb_cache_line_adaptor;

    import cache_types_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cache_line_adaptor_if bus ();

    cache_line_adaptor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          is_fill;
        logic [31:0] addr;
        cache_line_t line;
    } txn_t;

    txn_t              exp_q[$];
    logic [BEAT_W-1:0] beat_q[$];

    int checks = 0;
    int errors = 0;

    cache_line_t       mem_line    = '0;
    bit                manual      = 1'b0;
    logic              manual_resp = 1'b0;
    logic [BEAT_W-1:0] manual_data = '0;
    int                gap_fixed   = 0;  // -1 selects random gaps of 0..2 cycles

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic cache_line_t rand_line();
        cache_line_t l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_read_o"},    256'(bus.read_o),    256'd0);
        check({pfx, "_write_o"},   256'(bus.write_o),   256'd0);
        check({pfx, "_resp_o"},    256'(bus.resp_o),    256'd0);
        check({pfx, "_line_we_o"}, 256'(bus.line_we_o), 256'd0);
        check({pfx, "_address_o"}, 256'(bus.address_o), 256'd0);
        check({pfx, "_line_o"},    bus.line_o,          256'd0);
        check({pfx, "_burst_o"},   256'(bus.burst_o),   256'd0);
    endtask

    // Memory model: serves beat k of mem_line whenever a burst is open.
    initial begin : responder
        int k      = 0;
        int wait_n = 0;
        bit active = 1'b0;
        bus.resp_i  = 1'b0;
        bus.burst_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.resp_i && active) k++;
            active = bus.read_o || bus.write_o;
            if (!active) begin
                k      = 0;
                wait_n = (gap_fixed >= 0) ? gap_fixed : int'($urandom_range(0, 2));
            end
            if (manual) begin
                bus.resp_i  = manual_resp;
                bus.burst_i = manual_data;
            end else if (active && k < int'(BEATS) && wait_n == 0) begin
                bus.resp_i  = 1'b1;
                bus.burst_i = mem_line[BEAT_W*k +: BEAT_W];
                wait_n      = (gap_fixed >= 0) ? gap_fixed : int'($urandom_range(0, 2));
            end else begin
                bus.resp_i  = 1'b0;
                bus.burst_i = {$urandom, $urandom};
                if (wait_n > 0) wait_n--;
            end
        end
    end

    initial begin : monitor
        int   cyc       = 0;
        int   last_beat = -100;
        int   beats     = 0;
        txn_t t;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                beats = 0;
                continue;
            end
            if (beats > 0 && beats < int'(BEATS)) begin
                check("req_held", 256'(bus.read_o | bus.write_o), 256'd1);
            end
            if (bus.resp_i && bus.write_o) begin
                if (beat_q.size() == 0) check("wr_beat_queued", 256'(beat_q.size()), 256'd1);
                else check("burst_o", 256'(bus.burst_o), 256'(beat_q.pop_front()));
            end
            if (bus.resp_i && (bus.read_o || bus.write_o)) begin
                beats++;
                last_beat = cyc;
            end
            if (bus.resp_o) begin
                if (exp_q.size() == 0) begin
                    check("resp_queued", 256'(exp_q.size()), 256'd1);
                end else begin
                    t = exp_q.pop_front();
                    check("address_o", 256'(bus.address_o), 256'(t.addr));
                    check("line_we_o", 256'(bus.line_we_o),
                          t.is_fill ? 256'(32'hFFFF_FFFF) : 256'd0);
                    if (t.is_fill) check("line_o", bus.line_o, t.line);
                    check("beat_count", 256'(beats), 256'(BEATS));
                    check("resp_latency", 256'(cyc - last_beat), 256'd1);
                    check("req_dropped", 256'({bus.read_o, bus.write_o}), 256'd0);
                end
                beats = 0;
            end
        end
    end

    task automatic wait_resp(input bit scramble);
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus.resp_o || n > 300) break;
            n++;
            // Request was captured by now; later address/line changes must be ignored.
            if (scramble && n == 2) begin
                bus.address_i = $urandom;
                bus.line_i    = rand_line();
            end
        end
        check("resp_arrived", 256'(bus.resp_o), 256'd1);
    endtask

    task automatic run_txn(input bit fill, input logic [31:0] addr,
                           input cache_line_t wline, input cache_line_t mline);
        txn_t t;
        @(posedge clk);
        #1;
        mem_line  = mline;
        t.is_fill = fill;
        t.addr    = {addr[31:5], 5'b0};
        t.line    = fill ? mline : wline;
        exp_q.push_back(t);
        if (!fill) for (int i = 0; i < int'(BEATS); i++) beat_q.push_back(wline[BEAT_W*i +: BEAT_W]);
        bus.address_i = addr;
        bus.line_i    = wline;
        bus.read_i    = fill;
        bus.write_i   = !fill;
        wait_resp(1'b1);
        @(posedge clk);
        #1;
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
    endtask

    task automatic do_priority();
        txn_t        t;
        cache_line_t wl;
        cache_line_t ml;
        wl = rand_line();
        ml = rand_line();
        @(posedge clk);
        #1;
        mem_line  = ml;
        t.is_fill = 1'b0;
        t.addr    = 32'h0BAD_F000;
        t.line    = wl;
        exp_q.push_back(t);
        t.is_fill = 1'b1;
        t.line    = ml;
        exp_q.push_back(t);
        for (int i = 0; i < int'(BEATS); i++) beat_q.push_back(wl[BEAT_W*i +: BEAT_W]);
        bus.address_i = 32'h0BAD_F00D;
        bus.line_i    = wl;
        bus.read_i    = 1'b1;
        bus.write_i   = 1'b1;
        wait_resp(1'b0);
        @(posedge clk);
        #1;
        bus.write_i = 1'b0;
        @(negedge clk);
        check("prio_idle_gap", 256'({bus.read_o, bus.write_o}), 256'd0);
        @(negedge clk);
        check("prio_fill_start", 256'({bus.read_o, bus.write_o}), 256'b10);
        wait_resp(1'b0);
        @(posedge clk);
        #1;
        bus.read_i = 1'b0;
    endtask

    task automatic do_reset_mid_burst();
        manual      = 1'b1;
        manual_resp = 1'b0;
        @(posedge clk);
        #1;
        bus.address_i = 32'h8000_1234;
        bus.read_i    = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        manual_resp = 1'b1;
        manual_data = {16{4'hA}};
        @(negedge clk);
        manual_data = {16{4'hB}};
        @(negedge clk);
        manual_resp = 1'b0;
        @(negedge clk);
        check("rst_pre_read_o", 256'(bus.read_o), 256'd1);
        rst_n      = 1'b0;
        bus.read_i = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        rst_n       = 1'b1;
        manual_resp = 1'b1;
        manual_data = {16{4'hC}};
        @(negedge clk);
        manual_data = {16{4'hD}};
        repeat (2) begin
            @(negedge clk);
            manual_resp = 1'b0;
            check("stray_resp_o", 256'(bus.resp_o), 256'd0);
            check("stray_line_o", bus.line_o, 256'd0);
            check("stray_read_o", 256'(bus.read_o), 256'd0);
        end
        manual = 1'b0;
    endtask

    initial begin : main
        cache_line_t fill_line;
        cache_line_t wb_line;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.address_i = '0;
        bus.line_i    = '0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        gap_fixed = 0;
        fill_line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        run_txn(1'b1, 32'h1234_5678, rand_line(), fill_line);

        wb_line = {64'hDEAD_BEEF_0000_0000, 64'h0000_0000_0000_0000,
                   64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_CAFE};
        run_txn(1'b0, 32'hCAFE_0040, wb_line, rand_line());
        @(negedge clk);
        check("line_o_hold", bus.line_o, fill_line);

        gap_fixed = 3;
        run_txn(1'b1, $urandom, rand_line(), rand_line());
        gap_fixed = 0;

        do_priority();
        do_reset_mid_burst();
        run_txn(1'b1, 32'h4000_00FF, rand_line(), rand_line());

        gap_fixed = -1;
        repeat (24) run_txn($urandom_range(0, 1) == 1, $urandom, rand_line(), rand_line());

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 256'(exp_q.size() + beat_q.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation still running (got no finish, expected finish)");
        $fatal(1, "global timeout");
    end

endmodule
